// File: rtl/level_two_collision_detector.sv
// Level-two collision detector: counts player/level overlapping pixels per
// frame and issues one registered collision pulse per qualifying frame,
// followed by a programmable number of blocked (cooldown) frames.
// Optional build macro: COLLISION_FIRST_EDGE_EN (report the first-contact
// edge code instead of the OR of all overlapping edge codes).
module level_two_collision_detector #(
    parameter int unsigned PIXEL_COUNT_BITS = 10,
    parameter int unsigned MIN_HIT_PIXELS   = 4,
    parameter int unsigned COOLDOWN_FRAMES  = 2,
    parameter int unsigned EDGE_BITS        = 4
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic                        enable,
    input  logic                        playerDrawingRequest,
    input  logic                        levelDrawingRequest,
    input  logic [EDGE_BITS-1:0]        levelHitEdgeCode,
    output logic                        collision,
    output logic [EDGE_BITS-1:0]        collisionEdgeCode,
    output logic [PIXEL_COUNT_BITS-1:0] hitPixelCount
);

    localparam int unsigned CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [PIXEL_COUNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT, COOLDOWN} state_t;

    // A zero threshold would report every frame; reject it at elaboration.
    generate
        if (MIN_HIT_PIXELS == 0) begin : g_min_hit_check
            $error("MIN_HIT_PIXELS must be at least 1");
        end
    endgenerate

    state_t                      state_q, state_d;
    logic [PIXEL_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [EDGE_BITS-1:0]        edge_q, edge_d;
    logic [CD_W-1:0]             cd_q, cd_d;
    logic                        coll_d;
    logic [EDGE_BITS-1:0]        code_d;
    logic [PIXEL_COUNT_BITS-1:0] hpc_d;

    logic                        overlap_c;
    logic [PIXEL_COUNT_BITS-1:0] cnt_inc_c;
    logic [EDGE_BITS-1:0]        edge_upd_c;
    logic [PIXEL_COUNT_BITS-1:0] frame_cnt_c;
    logic [EDGE_BITS-1:0]        frame_edge_c;
    logic                        hit_c;

    // Per-pixel datapath terms: overlap, saturating count, edge merge, frame restart values.
    always_comb begin
        overlap_c    = playerDrawingRequest & levelDrawingRequest;
        cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PIXEL_COUNT_BITS'(1);
`ifdef COLLISION_FIRST_EDGE_EN
        edge_upd_c   = (cnt_q == '0) ? levelHitEdgeCode : edge_q;
`else
        edge_upd_c   = edge_q | levelHitEdgeCode;
`endif
        frame_cnt_c  = PIXEL_COUNT_BITS'(overlap_c);
        frame_edge_c = overlap_c ? levelHitEdgeCode : '0;
        hit_c        = (32'(cnt_q) >= MIN_HIT_PIXELS);
    end

    // Next-state and next-output logic; an overlap on startOfFrame opens the new frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        cd_d    = cd_q;
        coll_d  = 1'b0;
        code_d  = collisionEdgeCode;
        hpc_d   = hitPixelCount;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            edge_d  = '0;
            cd_d    = '0;
        end else begin
            if (state_q != IDLE) begin
                if (startOfFrame) begin
                    hpc_d  = cnt_q;
                    cnt_d  = frame_cnt_c;
                    edge_d = frame_edge_c;
                end else if (overlap_c) begin
                    cnt_d  = cnt_inc_c;
                    edge_d = edge_upd_c;
                end
            end

            case (state_q)
                IDLE: begin
                    if (startOfFrame) begin
                        state_d = ACCUM;
                        cnt_d   = frame_cnt_c;
                        edge_d  = frame_edge_c;
                    end
                end
                ACCUM: begin
                    if (startOfFrame && hit_c) begin
                        state_d = REPORT;
                        coll_d  = 1'b1;
                        code_d  = edge_q;
                    end
                end
                REPORT: begin
                    state_d = (COOLDOWN_FRAMES > 0) ? COOLDOWN : ACCUM;
                    cd_d    = CD_W'(COOLDOWN_FRAMES);
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cd_q <= CD_W'(1)) begin
                            state_d = ACCUM;
                            cd_d    = '0;
                        end else begin
                            cd_d    = cd_q - CD_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            edge_q            <= '0;
            cd_q              <= '0;
            collision         <= 1'b0;
            collisionEdgeCode <= '0;
            hitPixelCount     <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            edge_q            <= edge_d;
            cd_q              <= cd_d;
            collision         <= coll_d;
            collisionEdgeCode <= code_d;
            hitPixelCount     <= hpc_d;
        end
    end

endmodule

// File: tb/tb_level_two_collision_detector.sv
// Bench for level_two_collision_detector: default instance checked through a
// report scoreboard plus inline checks; a 3-bit counter instance checks saturation.
module tb_level_two_collision_detector;

    localparam int FRAME_LEN = 24;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       enable;
    logic       playerDrawingRequest;
    logic       levelDrawingRequest;
    logic [3:0] levelHitEdgeCode;

    logic       collision;
    logic [3:0] collisionEdgeCode;
    logic [9:0] hitPixelCount;
    logic       sat_collision;
    logic [3:0] sat_code;
    logic [2:0] sat_hpc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] code;
        logic [9:0] cnt;
    } exp_t;
    exp_t sb_q[$];

`ifdef COLLISION_FIRST_EDGE_EN
    localparam logic [3:0] PLAN2_CODE = 4'h8;
`else
    localparam logic [3:0] PLAN2_CODE = 4'h9;
`endif

    always #5 clk = ~clk;

    level_two_collision_detector u_dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .enable               (enable),
        .playerDrawingRequest (playerDrawingRequest),
        .levelDrawingRequest  (levelDrawingRequest),
        .levelHitEdgeCode     (levelHitEdgeCode),
        .collision            (collision),
        .collisionEdgeCode    (collisionEdgeCode),
        .hitPixelCount        (hitPixelCount)
    );

    level_two_collision_detector #(.PIXEL_COUNT_BITS(3)) u_sat (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .enable               (enable),
        .playerDrawingRequest (playerDrawingRequest),
        .levelDrawingRequest  (levelDrawingRequest),
        .levelHitEdgeCode     (levelHitEdgeCode),
        .collision            (sat_collision),
        .collisionEdgeCode    (sat_code),
        .hitPixelCount        (sat_hpc)
    );

    // Scoreboard: every pulse of the default instance must match a queued report.
    always @(negedge clk) begin
        exp_t e;
        if (collision === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: code=%h count=%0d with no report queued",
                         collisionEdgeCode, hitPixelCount);
            end else begin
                e = sb_q.pop_front();
                if (collisionEdgeCode !== e.code || hitPixelCount !== e.cnt) begin
                    failures++;
                    $display("FAIL report_payload: code=%h count=%0d expected code=%h count=%0d",
                             collisionEdgeCode, hitPixelCount, e.code, e.cnt);
                end
            end
        end
    end

    task automatic apply(input logic sof, input logic p, input logic l, input logic [3:0] c);
        startOfFrame         = sof;
        playerDrawingRequest = p;
        levelDrawingRequest  = l;
        levelHitEdgeCode     = c;
        @(posedge clk);
        #1;
    endtask

    // Frame-start cycle; without overlap only the level requests, with code F.
    task automatic sof_cycle(input logic ov, input logic [3:0] c);
        apply(1'b1, ov, 1'b1, ov ? c : 4'hF);
    endtask

    // Rest of a frame: n overlaps with nibble codes, then one-sided requests.
    task automatic body(input int n, input logic [31:0] codes);
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            if (i < n)      apply(1'b0, 1'b1, 1'b1, codes[(i % 8) * 4 +: 4]);
            else if (i[0])  apply(1'b0, 1'b0, 1'b1, 4'hF);
            else            apply(1'b0, 1'b1, 1'b0, 4'hF);
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b0, 1'b0, 4'h0);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        enable = 1'b0;
        startOfFrame = 1'b0;
        playerDrawingRequest = 1'b0;
        levelDrawingRequest = 1'b0;
        levelHitEdgeCode = 4'h0;
        #2 resetN = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (collision !== 1'b0 || collisionEdgeCode !== 4'h0 || hitPixelCount !== 10'd0) begin
            failures++;
            $display("FAIL reset_values: coll=%b code=%h count=%0d expected 0/0/0",
                     collision, collisionEdgeCode, hitPixelCount);
        end
        resetN = 1'b1;
        enable = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_report();
        restart();
        sof_cycle(1'b0, 4'h0);
        body(5, 32'h0000_0188);
        sb_q.push_back(exp_t'{code: PLAN2_CODE, cnt: 10'd5});
        sof_cycle(1'b0, 4'h0);
        checks++;
        if (collision !== 1'b1 || hitPixelCount !== 10'd5 || collisionEdgeCode !== PLAN2_CODE) begin
            failures++;
            $display("FAIL report_latency: coll=%b count=%0d code=%h expected 1/5/%h",
                     collision, hitPixelCount, collisionEdgeCode, PLAN2_CODE);
        end
        apply(1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (collision !== 1'b0) begin
            failures++;
            $display("FAIL report_width: coll=%b expected 0", collision);
        end
    endtask

    task automatic test_below_threshold();
        restart();
        sof_cycle(1'b0, 4'h0);
        body(3, 32'h2222_2222);
        sof_cycle(1'b0, 4'h0);
        checks++;
        if (collision !== 1'b0 || hitPixelCount !== 10'd3 || collisionEdgeCode !== PLAN2_CODE) begin
            failures++;
            $display("FAIL below_threshold: coll=%b count=%0d code=%h expected 0/3/%h",
                     collision, hitPixelCount, collisionEdgeCode, PLAN2_CODE);
        end
        body(0, 32'h0);
    endtask

    task automatic test_cooldown();
        logic [3:0] fcode[4] = '{4'h2, 4'h4, 4'h4, 4'h1};
        restart();
        sof_cycle(1'b0, 4'h0);
        for (int f = 0; f < 4; f++) begin
            body(10, {8{fcode[f]}});
            if (f == 0 || f == 3) sb_q.push_back(exp_t'{code: fcode[f], cnt: 10'd10});
            sof_cycle(1'b0, 4'h0);
            checks++;
            if (collision !== ((f == 0 || f == 3) ? 1'b1 : 1'b0) || hitPixelCount !== 10'd10) begin
                failures++;
                $display("FAIL cooldown_frame%0d: coll=%b count=%0d expected %0b/10",
                         f + 1, collision, hitPixelCount, (f == 0 || f == 3));
            end
        end
        body(0, 32'h0);
    endtask

    task automatic test_sof_overlap();
        restart();
        sof_cycle(1'b0, 4'h0);
        body(4, 32'h2222_2222);
        sb_q.push_back(exp_t'{code: 4'h2, cnt: 10'd4});
        sof_cycle(1'b1, 4'h8);
        checks++;
        if (collision !== 1'b1 || hitPixelCount !== 10'd4 || collisionEdgeCode !== 4'h2) begin
            failures++;
            $display("FAIL min_boundary: coll=%b count=%0d code=%h expected 1/4/2",
                     collision, hitPixelCount, collisionEdgeCode);
        end
        body(0, 32'h0);
        sof_cycle(1'b0, 4'h0);
        checks++;
        if (collision !== 1'b0 || hitPixelCount !== 10'd1) begin
            failures++;
            $display("FAIL sof_overlap_new_frame: coll=%b count=%0d expected 0/1",
                     collision, hitPixelCount);
        end
    endtask

    task automatic test_midframe_reset();
        restart();
        sof_cycle(1'b0, 4'h0);
        body(7, 32'h3333_3333);
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (collision !== 1'b0 || collisionEdgeCode !== 4'h0 || hitPixelCount !== 10'd0) begin
            failures++;
            $display("FAIL async_reset: coll=%b code=%h count=%0d expected 0/0/0",
                     collision, collisionEdgeCode, hitPixelCount);
        end
        checks++;
        if (2'(u_dut.state_q) !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d expected 0", 2'(u_dut.state_q));
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
        sof_cycle(1'b0, 4'h0);
        body(0, 32'h0);
        sof_cycle(1'b0, 4'h0);
        checks++;
        if (collision !== 1'b0 || hitPixelCount !== 10'd0) begin
            failures++;
            $display("FAIL post_reset_frame: coll=%b count=%0d expected 0/0",
                     collision, hitPixelCount);
        end
    endtask

    task automatic test_saturation_disable();
        restart();
        sof_cycle(1'b0, 4'h0);
        body(20, 32'h4444_4444);
        sb_q.push_back(exp_t'{code: 4'h4, cnt: 10'd20});
        sof_cycle(1'b0, 4'h0);
        checks++;
        if (sat_collision !== 1'b1 || sat_hpc !== 3'd7 || sat_code !== 4'h4) begin
            failures++;
            $display("FAIL saturation: coll=%b count=%0d code=%h expected 1/7/4",
                     sat_collision, sat_hpc, sat_code);
        end
        checks++;
        if (collision !== 1'b1 || hitPixelCount !== 10'd20) begin
            failures++;
            $display("FAIL wide_count: coll=%b count=%0d expected 1/20", collision, hitPixelCount);
        end
        enable = 1'b0;
        apply(1'b0, 1'b1, 1'b1, 4'h1);
        checks++;
        if (sat_collision !== 1'b0 || collision !== 1'b0) begin
            failures++;
            $display("FAIL disable_in_report: coll=%b/%b expected 0/0", sat_collision, collision);
        end
        checks++;
        if (2'(u_sat.state_q) !== 2'd0 || u_sat.cnt_q !== 3'd0 || u_sat.edge_q !== 4'h0) begin
            failures++;
            $display("FAIL disable_clears: state=%0d cnt=%0d edge=%h expected 0/0/0",
                     2'(u_sat.state_q), u_sat.cnt_q, u_sat.edge_q);
        end
        checks++;
        if (sat_hpc !== 3'd7 || sat_code !== 4'h4) begin
            failures++;
            $display("FAIL disable_retains: count=%0d code=%h expected 7/4", sat_hpc, sat_code);
        end
        apply(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_report();
        test_below_threshold();
        test_cooldown();
        test_sof_overlap();
        test_midframe_reset();
        test_saturation_disable();
        apply(1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL missing_reports: %0d queued reports never seen, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
